// File: rtl/code_entry_buffer.sv
// Keypad code-entry buffer: collects MIN_DIGITS..MAX_DIGITS digits with backspace/enter and freezes the submitted code.
// Optional inactivity auto-clear is built when ENTRY_TIMEOUT_EN is defined.
module code_entry_buffer #(
  parameter int DIGIT_W        = 4,
  parameter int MAX_DIGITS     = 8,
  parameter int MIN_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clear_entry,
  input  logic [DIGIT_W-1:0]                    digit,
  input  logic                                  digit_valid,
  input  logic                                  backspace,
  input  logic                                  enter,
  output logic [MAX_DIGITS*DIGIT_W-1:0]         entered_code,
  output logic [$clog2(MAX_DIGITS+1)-1:0]       digit_count,
  output logic                                  code_ready,
  output logic                                  done,
  output logic                                  reject,
  output logic                                  overflow,
  output logic                                  timed_out
);

  localparam int CNT_W  = $clog2(MAX_DIGITS+1);
  localparam int CODE_W = MAX_DIGITS*DIGIT_W;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_DIGITS);
  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_DIGITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_DIGITS-1);

  if (MAX_DIGITS < 2) begin : g_bad_max
    $error("MAX_DIGITS must be at least 2");
  end
  if (MIN_DIGITS < 1 || MIN_DIGITS > MAX_DIGITS) begin : g_bad_min
    $error("MIN_DIGITS must lie in 1..MAX_DIGITS");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {S_EMPTY, S_ENTRY, S_FULL, S_HOLD} state_e;
  typedef enum logic [2:0] {
    ACT_NONE, ACT_CLEAR, ACT_TIMEOUT, ACT_ACCEPT, ACT_REJECT, ACT_BACK, ACT_DIGIT, ACT_OVF
  } act_e;

  state_e              state_q, state_d;
  act_e                act;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                done_q, reject_q, overflow_q;
  logic                timeout_hit;

  // Single winning action per cycle; HOLD only listens to clear_entry.
  always_comb begin
    act = ACT_NONE;
    if (clear_entry) begin
      act = ACT_CLEAR;
    end else if (state_q != S_HOLD) begin
      if (timeout_hit) begin
        act = ACT_TIMEOUT;
      end else if (enter) begin
        act = (count_q >= MIN_CNT) ? ACT_ACCEPT : ACT_REJECT;
      end else if (backspace) begin
        if (state_q != S_EMPTY) act = ACT_BACK;
      end else if (digit_valid) begin
        act = (state_q == S_FULL) ? ACT_OVF : ACT_DIGIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (act)
      ACT_CLEAR, ACT_TIMEOUT, ACT_REJECT: state_d = S_EMPTY;
      ACT_ACCEPT:                         state_d = S_HOLD;
      ACT_BACK:  state_d = (count_q == CNT_W'(1)) ? S_EMPTY : S_ENTRY;
      ACT_DIGIT: state_d = (count_q == LAST_CNT) ? S_FULL : S_ENTRY;
      default:   state_d = state_q;
    endcase
  end

  always_comb begin
    code_d  = code_q;
    count_d = count_q;
    case (act)
      ACT_CLEAR, ACT_TIMEOUT, ACT_REJECT: begin
        code_d  = '0;
        count_d = '0;
      end
      ACT_DIGIT: begin
        code_d  = {code_q[CODE_W-DIGIT_W-1:0], digit};
        count_d = count_q + 1'b1;
      end
      ACT_BACK: begin
        code_d  = code_q >> DIGIT_W;
        count_d = count_q - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      code_q     <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      reject_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      code_q     <= code_d;
      count_q    <= count_d;
      done_q     <= (act == ACT_ACCEPT);
      reject_q   <= (act == ACT_REJECT);
      overflow_q <= (act == ACT_OVF);
    end
  end

`ifdef ENTRY_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES-1);

  logic [TMR_W-1:0] timer_q, timer_d;
  logic             timed_out_q;

  // Timer value = idle edges since the last key action; expiry lands TIMEOUT_CYCLES edges after it.
  assign timeout_hit = ((state_q == S_ENTRY) || (state_q == S_FULL)) && (timer_q == TMR_LAST);

  always_comb begin
    timer_d = '0;
    if (((state_d == S_ENTRY) || (state_d == S_FULL)) &&
        !((act == ACT_DIGIT) || (act == ACT_BACK) || (act == ACT_OVF)))
      timer_d = timer_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q     <= '0;
      timed_out_q <= 1'b0;
    end else begin
      timer_q     <= timer_d;
      timed_out_q <= (act == ACT_TIMEOUT);
    end
  end

  assign timed_out = timed_out_q;
`else
  assign timeout_hit = 1'b0;
  assign timed_out   = 1'b0;
`endif

  always_comb begin
    entered_code = code_q;
    digit_count  = count_q;
    code_ready   = (state_q == S_HOLD);
    done         = done_q;
    reject       = reject_q;
    overflow     = overflow_q;
  end

endmodule
